// File: rtl/prio_arbiter_pkg.sv
// Shared types and constants for the four-requester priority arbiter.
package prio_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 priority encoder; bit 3 wins.
module prio_enc4 (
  input  logic [3:0] vec,
  output logic [1:0] id,
  output logic       any
);

  // Highest set bit selects the index; any flags a nonzero vector.
  always_comb begin
    id  = 2'd0;
    any = 1'b1;
    if (vec[3]) begin
      id = 2'd3;
    end else if (vec[2]) begin
      id = 2'd2;
    end else if (vec[1]) begin
      id = 2'd1;
    end else if (vec[0]) begin
      id = 2'd0;
    end else begin
      any = 1'b0;
    end
  end

endmodule

// File: rtl/prio_arbiter_4.sv
// Fixed-priority four-requester arbiter with a hold limit and a one-round
// mask on requesters whose grant timed out.
module prio_arbiter_4
  import prio_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t             state_r;
  logic [NUM_REQ-1:0] mask_r;
  logic [CNT_W-1:0]   hold_cnt_r;

  logic [NUM_REQ-1:0] masked_s;
  logic [NUM_REQ-1:0] eff_req_s;
  logic [NUM_REQ-1:0] mask_nxt_s;
  logic               fallback_s;
  logic               release_s;
  logic               limit_s;
  logic [ID_W-1:0]    id_s;
  logic               any_s;

  // Effective request vector; falls back to raw req when the mask blocks everyone.
  always_comb begin
    masked_s   = req & ~mask_r;
    fallback_s = (masked_s == 4'b0000) && (req != 4'b0000);
    if (fallback_s) begin
      eff_req_s = req;
    end else begin
      eff_req_s = masked_s;
    end
  end

  prio_enc4 u_enc (
    .vec (eff_req_s),
    .id  (id_s),
    .any (any_s)
  );

  // Release takes precedence over the limit when both occur at the same edge.
  always_comb begin
    release_s = ~req[gnt_id];
    limit_s   = (hold_cnt_r == HOLD_MAX);
  end

  // Next round mask; a bit never survives its requester going low.
  always_comb begin
    mask_nxt_s = mask_r;
    case (state_r)
      IDLE: begin
        mask_nxt_s = fallback_s ? 4'b0000 : mask_r;
        mask_nxt_s = any_s ? (mask_nxt_s & onehot(id_s)) : mask_nxt_s;
      end
      BUSY: begin
        if (!release_s && limit_s) begin
          mask_nxt_s = mask_r | onehot(gnt_id);
        end else begin
          mask_nxt_s = mask_r;
        end
      end
      default: mask_nxt_s = 4'b0000;
    endcase
    mask_nxt_s = mask_nxt_s & req;
  end

  // Grant state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      mask_r     <= 4'b0000;
      hold_cnt_r <= '0;
      gnt        <= 4'b0000;
      gnt_id     <= 2'd0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      mask_r  <= mask_nxt_s;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            gnt        <= onehot(id_s);
            gnt_id     <= id_s;
            gnt_valid  <= 1'b1;
            hold_cnt_r <= CNT_W'(1);
            state_r    <= BUSY;
          end
        end
        BUSY: begin
          if (release_s) begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            state_r   <= IDLE;
          end else if (limit_s) begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
            state_r   <= IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          gnt       <= 4'b0000;
          gnt_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_arbiter_4.sv
// Bench for prio_arbiter_4 with MAX_HOLD = 4: a cycle model feeds a scoreboard
// queue, and each scenario task adds its own direct checks.
module tb_prio_arbiter_4;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic       m_busy;
  logic [3:0] m_mask;
  int         m_cnt;
  logic [3:0] m_gnt;
  logic [1:0] m_id;
  logic       m_valid;
  logic       m_to;

  prio_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic [3:0] r, input logic rs);
    logic [3:0] eff;
    logic [3:0] mk;
    if (rs) begin
      m_busy = 1'b0; m_mask = 4'b0000; m_cnt = 0;
      m_gnt = 4'b0000; m_id = 2'd0; m_valid = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (!m_busy) begin
        mk  = m_mask;
        eff = r & ~m_mask;
        if (eff == 4'b0000 && r != 4'b0000) begin
          eff = r;
          mk  = 4'b0000;
        end
        for (int b = 0; b < 4; b++) begin
          if (eff[b]) m_id = 2'(b);
        end
        if (eff != 4'b0000) begin
          m_gnt = 4'b0000;
          m_gnt[m_id] = 1'b1;
          m_valid = 1'b1;
          m_cnt = 1;
          m_busy = 1'b1;
          mk = mk & m_gnt;
        end
        m_mask = mk & r;
      end else begin
        if (!r[m_id]) begin
          m_gnt = 4'b0000; m_valid = 1'b0; m_busy = 1'b0;
        end else if (m_cnt == MAXH) begin
          m_gnt = 4'b0000; m_valid = 1'b0; m_busy = 1'b0; m_to = 1'b1;
          m_mask[m_id] = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
        m_mask = m_mask & r;
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the model's expected outputs.
  task automatic drive(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    model_step(r, rs);
    sb.push_back('{gnt: m_gnt, id: m_id, valid: m_valid, to: m_to});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one expected entry is consumed per clock edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got gnt=%b id=%0d v=%b to=%b exp gnt=%b id=%0d v=%b to=%b",
                 $time, gnt, gnt_id, gnt_valid, timeout, e.gnt, e.id, e.valid, e.to);
      end
    end
  end

  task automatic test_reset();
    drive(4'b0000, 1'b1);
    drive(4'b1111, 1'b1);
    n_tests++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp %b", {gnt, gnt_id, gnt_valid, timeout}, 8'b0);
    end
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_single();
    logic saw_to;
    saw_to = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 1'b0);
      saw_to = saw_to | timeout;
      n_tests++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL single_grant got gnt=%b id=%0d v=%b exp gnt=0100 id=2 v=1", gnt, gnt_id, gnt_valid);
      end
    end
    drive(4'b0000, 1'b0);
    saw_to = saw_to | timeout;
    n_tests++;
    if (gnt !== 4'b0000 || saw_to !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release got gnt=%b saw_to=%b exp gnt=0000 saw_to=0", gnt, saw_to);
    end
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_priority();
    drive(4'b0011, 1'b0);
    drive(4'b1011, 1'b0);
    drive(4'b1011, 1'b0);
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL no_preempt got %b exp 0010", gnt);
    end
    drive(4'b1001, 1'b0);
    n_tests++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL prio_gap got %b exp 0000", gnt);
    end
    drive(4'b1001, 1'b0);
    n_tests++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      n_fail++;
      $display("FAIL prio_next got gnt=%b id=%0d exp gnt=1000 id=3", gnt, gnt_id);
    end
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_fairness();
    logic [3:0] eg;
    for (int i = 0; i < 20; i++) begin
      drive(4'b1111, 1'b0);
      eg = (i % 5 == 4) ? 4'b0000 : (((i / 5) % 2 == 1) ? 4'b0100 : 4'b1000);
      n_tests++;
      if (gnt !== eg || timeout !== (i % 5 == 4)) begin
        n_fail++;
        $display("FAIL fairness[%0d] got gnt=%b to=%b exp gnt=%b to=%b", i, gnt, timeout, eg, (i % 5 == 4));
      end
    end
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_lone();
    logic [3:0] eg;
    for (int i = 0; i < 10; i++) begin
      drive(4'b1000, 1'b0);
      eg = (i % 5 == 4) ? 4'b0000 : 4'b1000;
      n_tests++;
      if (gnt !== eg || timeout !== (i % 5 == 4)) begin
        n_fail++;
        $display("FAIL lone[%0d] got gnt=%b to=%b exp gnt=%b to=%b", i, gnt, timeout, eg, (i % 5 == 4));
      end
    end
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_limit_release();
    for (int i = 0; i < 4; i++) drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b0);
    n_tests++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_release got gnt=%b to=%b exp gnt=0000 to=0", gnt, timeout);
    end
    drive(4'b0010, 1'b0);
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL limit_regrant got %b exp 0010", gnt);
    end
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b1);
    n_tests++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_mid got %b exp %b", {gnt, gnt_id, gnt_valid, timeout}, 8'b0);
    end
    drive(4'b0001, 1'b0);
    n_tests++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_regrant got gnt=%b id=%0d exp gnt=0001 id=0", gnt, gnt_id);
    end
    drive(4'b0000, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] r;
    for (int i = 0; i < 200; i++) begin
      r = 4'($urandom_range(0, 15));
      drive(r, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end
    drive(4'b0000, 1'b0);
  endtask

  initial begin
    req = 4'b0000;
    rst = 1'b1;
    test_reset();
    test_single();
    test_priority();
    test_fairness();
    test_lone();
    test_limit_release();
    test_reset_mid();
    test_random();
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
